// File: rtl/cordic_ln_if.sv
// ============================================================================
// Module      : cordic_ln_if
// Description : Start/done handshake bundle for the cordic_ln logarithm core.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cordic_ln_if;
  logic        start;
  logic [15:0] x_in;
  logic [15:0] ln_out;
  logic        done;
  logic        busy;
  logic        err;

  modport master (
    output start, x_in,
    input  ln_out, done, busy, err
  );

  modport slave (
    input  start, x_in,
    output ln_out, done, busy, err
  );
endinterface

`default_nettype wire

// File: rtl/cordic_ln.sv
// ============================================================================
// Module      : cordic_ln
// Description : Hyperbolic vectoring CORDIC, ln() of unsigned Q8.8 -> Q4.11.
//               Optional macro CORDIC_LN_ROUND_EN selects round-half-away-from-
//               zero on the final 16->11 fraction conversion (else truncate).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cordic_ln #(
  parameter int ITER = 14
) (
  input  logic        clk,
  input  logic        reset,
  cordic_ln_if.slave  bus
);

  localparam int c_N = ITER + ((ITER >= 4) ? 1 : 0) + ((ITER >= 13) ? 1 : 0);
  localparam logic signed [19:0] c_ONE = 20'sh10000;
  localparam logic signed [23:0] c_LN2 = 24'sd45426;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_NORM = 2'd1,
    S_ITER = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t             r_state;
  logic [15:0]        r_x;
  logic signed [3:0]  r_k;
  logic               r_zero;
  logic signed [19:0] r_xc;
  logic signed [19:0] r_yc;
  logic signed [19:0] r_zc;
  logic [4:0]         r_step;
  logic [15:0]        r_ln_out;
  logic               r_done;
  logic               r_busy;
  logic               r_err;

  // Micro-step number to CORDIC index; indices 4 and 13 each occur twice.
  function automatic logic [4:0] f_idx(input logic [4:0] s);
    if (s < 5'd4)
      return s + 5'd1;
    else if (s < 5'd14)
      return s;
    else
      return s - 5'd1;
  endfunction

  function automatic logic signed [19:0] f_atanh(input logic [4:0] i);
    case (i)
      5'd1:    return 20'sd35999;
      5'd2:    return 20'sd16739;
      5'd3:    return 20'sd8235;
      5'd4:    return 20'sd4101;
      5'd5:    return 20'sd2049;
      5'd6:    return 20'sd1024;
      5'd7:    return 20'sd512;
      5'd8:    return 20'sd256;
      5'd9:    return 20'sd128;
      5'd10:   return 20'sd64;
      5'd11:   return 20'sd32;
      5'd12:   return 20'sd16;
      5'd13:   return 20'sd8;
      5'd14:   return 20'sd4;
      5'd15:   return 20'sd2;
      5'd16:   return 20'sd1;
      default: return 20'sd0;
    endcase
  endfunction

  logic [3:0]         w_p;
  logic [4:0]         w_sh;
  logic signed [19:0] w_m;
  logic [4:0]         w_idx;
  logic signed [19:0] w_xs;
  logic signed [19:0] w_ys;
  logic signed [19:0] w_at;
  logic signed [23:0] w_z2;
  logic signed [23:0] w_k24;
  logic signed [23:0] w_kl;
  logic signed [23:0] w_ln_full;
  logic signed [23:0] w_conv;
  logic [15:0]        w_sat;

  // Leading-one search: the highest set bit wins because it is assigned last.
  always_comb begin
    w_p = 4'd0;
    for (int i = 0; i < 16; i++) begin
      if (r_x[i])
        w_p = 4'(i);
    end
  end

  assign w_sh  = 5'd16 - {1'b0, w_p};
  assign w_m   = $signed({4'b0000, r_x} << w_sh);

  assign w_idx = f_idx(r_step);
  assign w_xs  = r_xc >>> w_idx;
  assign w_ys  = r_yc >>> w_idx;
  assign w_at  = f_atanh(w_idx);

  assign w_z2      = {{3{r_zc[19]}}, r_zc, 1'b0};
  assign w_k24     = {{20{r_k[3]}}, r_k};
  assign w_kl      = w_k24 * c_LN2;
  assign w_ln_full = w_z2 + w_kl;

`ifdef CORDIC_LN_ROUND_EN
  // Biasing negatives by 15 instead of 16 makes the floor shift round half away from zero.
  assign w_conv = w_ln_full[23] ? ((w_ln_full + 24'sd15) >>> 5)
                                : ((w_ln_full + 24'sd16) >>> 5);
`else
  assign w_conv = w_ln_full >>> 5;
`endif

  always_comb begin
    w_sat = w_conv[15:0];
    if (w_conv > 24'sd32767)
      w_sat = 16'h7FFF;
    else if (w_conv < -24'sd32768)
      w_sat = 16'h8000;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_x      <= '0;
      r_k      <= '0;
      r_zero   <= 1'b0;
      r_xc     <= '0;
      r_yc     <= '0;
      r_zc     <= '0;
      r_step   <= '0;
      r_ln_out <= '0;
      r_done   <= 1'b0;
      r_busy   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_x     <= bus.x_in;
            r_busy  <= 1'b1;
            r_state <= S_NORM;
          end
        end
        S_NORM: begin
          if (r_x == 16'd0) begin
            r_zero  <= 1'b1;
            r_state <= S_FIN;
          end else begin
            r_zero  <= 1'b0;
            r_k     <= $signed(w_p - 4'd8);
            r_xc    <= w_m + c_ONE;
            r_yc    <= w_m - c_ONE;
            r_zc    <= '0;
            r_step  <= '0;
            r_state <= S_ITER;
          end
        end
        S_ITER: begin
          // Drive Y toward zero; Z accumulates atanh(Y0/X0).
          if (r_yc[19]) begin
            r_xc <= r_xc + w_ys;
            r_yc <= r_yc + w_xs;
            r_zc <= r_zc - w_at;
          end else begin
            r_xc <= r_xc - w_ys;
            r_yc <= r_yc - w_xs;
            r_zc <= r_zc + w_at;
          end
          if (r_step == 5'(c_N - 1))
            r_state <= S_FIN;
          else
            r_step <= r_step + 5'd1;
        end
        S_FIN: begin
          if (r_zero) begin
            r_ln_out <= 16'h8000;
            r_err    <= 1'b1;
          end else begin
            r_ln_out <= w_sat;
            r_err    <= 1'b0;
          end
          r_done  <= 1'b1;
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.ln_out = r_ln_out;
  assign bus.done   = r_done;
  assign bus.busy   = r_busy;
  assign bus.err    = r_err;

endmodule

`default_nettype wire

// File: tb/tb_cordic_ln.sv
// ============================================================================
// Module      : tb_cordic_ln
// Description : Scoreboard bench for cordic_ln against a real-valued ln model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_cordic_ln;

  localparam int ITER = 14;
  localparam int N    = 16;
`ifdef CORDIC_LN_ROUND_EN
  localparam real TOL = 1.0;
`else
  localparam real TOL = 2.0;
`endif

  logic clk   = 1'b0;
  logic reset = 1'b1;

  cordic_ln_if bus ();

  cordic_ln #(.ITER(ITER)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [15:0] x;
    logic        e_err;
    real         e_val;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic real model_ln(input logic [15:0] x);
    return $ln($itor(x) / 256.0) * 2048.0;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse.
  exp_t m_e;
  int   m_act;
  real  m_diff;
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.done) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done: got done=1 expected no result pending (t=%0t)", $time);
        end else begin
          m_e = sb.pop_front();
          chk("latency", cyc - m_e.acc, m_e.e_err ? 2 : N + 2);
          chk("err", int'(bus.err), int'(m_e.e_err));
          chk("busy_at_done", int'(bus.busy), 0);
          m_act = int'($signed(bus.ln_out));
          if (m_e.e_err) begin
            chk("ln_out_zero", m_act, -32768);
          end else begin
            m_diff = $itor(m_act) - m_e.e_val;
            if (m_diff < 0.0) m_diff = -m_diff;
            n_tests++;
            if (m_diff > TOL) begin
              n_fail++;
              $display("FAIL ln_out x=%h: got %0d expected %f (+/-%0.1f)", m_e.x, m_act, m_e.e_val, TOL);
            end
          end
        end
      end else if (sb.size() > 0 && cyc >= sb[0].acc) begin
        chk("busy_during_op", int'(bus.busy), 1);
      end
    end
  end

  // Called at posedge+1 while the DUT is idle or presenting done.
  task automatic issue(input logic [15:0] x);
    exp_t e;
    e.x     = x;
    e.e_err = (x == 16'd0);
    e.e_val = (x == 16'd0) ? -32768.0 : model_ln(x);
    e.acc   = cyc + 1;
    sb.push_back(e);
    bus.start = 1'b1;
    bus.x_in  = x;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.x_in  = 16'($urandom);
  endtask

  task automatic wait_done(input int maxc);
    bit seen = 1'b0;
    for (int i = 0; i < maxc; i++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        seen = 1'b1;
        break;
      end
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL wait_done: got no done within %0d cycles expected done", maxc);
    end
  endtask

  task automatic run(input logic [15:0] x);
    issue(x);
    wait_done(40);
  endtask

  initial begin
    logic [15:0] dirs [7];
    dirs = '{16'h0100, 16'h0200, 16'h02B8, 16'h0001, 16'hFFFF, 16'h0000, 16'h0300};

    bus.start = 1'b0;
    bus.x_in  = 16'h0000;
    reset     = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_ln_out", int'(bus.ln_out), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_err", int'(bus.err), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    foreach (dirs[i]) run(dirs[i]);

    // start pulse while busy with a different operand must be ignored
    issue(16'h0400);
    repeat (5) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.x_in  = 16'h0800;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    wait_done(40);

    // idle gap then a fresh start
    repeat (4) @(posedge clk);
    #1;
    run(16'h1234);

    // asynchronous reset in the middle of the iterations
    issue(16'h0050);
    repeat (6) @(posedge clk);
    #1;
    reset = 1'b1;
    sb.delete();
    #1;
    chk("midreset_ln_out", int'(bus.ln_out), 0);
    chk("midreset_done", int'(bus.done), 0);
    chk("midreset_busy", int'(bus.busy), 0);
    chk("midreset_err", int'(bus.err), 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    chk("post_reset_busy", int'(bus.busy), 0);
    chk("post_reset_ln_out", int'(bus.ln_out), 0);

    for (int n = 0; n < 1000; n++) begin
      if ($urandom_range(0, 3) == 0) begin
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      run(16'($urandom_range(1, 65535)));
    end

    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected $finish");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/cordic_ln.md
Name: cordic_ln

Overview:
- Hyperbolic CORDIC in vectoring mode. Computes the natural logarithm of an unsigned Q8.8 input; it is the inverse companion to the existing rotation-mode exponential cordic.
- Same start/done handshake style as the exponential cordic. Sits beside it in the user project area, driven from wb_clk_i/wb_rst_i and IO/LA pins.
- Range reduction by leading-one normalisation, then `ln(x) = 2*atanh((m-1)/(m+1)) + k*ln2`.

Parameters:
- ITER, 14, number of distinct CORDIC indices i=1..ITER; legal range 8..16. Indices 4 and 13 are executed twice when i ≤ ITER.

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- start  input  1  request pulse; sampled only in IDLE
- x_in  input  16  unsigned Q8.8 operand; captured on the accepted start edge
- ln_out  output  16  signed Q4.11 result; held until the next result
- done  output  1  one-cycle pulse when ln_out/err update
- busy  output  1  high from the accepted start until done
- err  output  1  high with done when x_in==0; held until the next result

Behaviour:
- Clock and reset: one clock (clk). reset is asynchronous and active-high. Reset forces IDLE and drives ln_out=0, done=0, busy=0, err=0. All internal registers are cleared.
- FSM states:
  - IDLE: on start=1, capture x_in, set busy=1, go to NORM.
  - NORM (1 cycle):
    - If x==0, go to FIN with err pending.
    - Otherwise find p = position of the leading one (0..15) and set k = p-8 (signed, -8..7).
    - m = x normalised to [1,2), placed in internal Q3.16 (20-bit signed).
    - Load X=m+1, Y=m-1, Z=0 and step counter 0; go to ITER.
  - ITER: one micro-step per cycle.
    - d = +1 if Y<0 else -1.
    - X += d*(Y>>>i), Y += d*(X>>>i), Z -= d*atanh(2^-i), all using pre-update values.
    - Index sequence is 1,2,3,4,4,5,...,13,13,14..ITER. N = ITER + repeat count (N=16 for ITER=14).
    - After N steps go to FIN.
  - FIN (1 cycle):
    - Normal case: ln_full = 2*Z + k*LN2 (LN2 in Q3.16, computed at ≥24 bits). ln_out = ln_full converted from 16 to 11 fractional bits, then saturated to [0x8000, 0x7FFF]. err=0.
    - Zero case: ln_out=0x8000, err=1.
    - Pulse done=1, busy=0, return to IDLE.
- Latency: N+2 cycles from the start-sampling edge to done high (18 for ITER=14). Zero input takes 2 cycles.
- start while busy=1 is ignored; no queueing.
- Back-to-back: start may be asserted in the same cycle done is high. Because the FSM is already in IDLE, that start is accepted.
- x_in is don't-care except on the accepted edge.
- Reset mid-operation: computation is aborted, no done pulse is produced, and outputs return to reset values.
- atanh table: ITER entries in Q3.16 ROM, rounded to nearest.
- Accuracy: |ln_out - true| ≤ 2 LSB over the whole nonzero input range.

Optional Feature:
- CORDIC_LN_ROUND_EN
  - Defined: the 16→11 fraction conversion in FIN rounds half away from zero, and accuracy tightens to ≤1 LSB for ITER ≥ 14.
  - Undefined: the conversion truncates (arithmetic shift right by 5, toward −∞), and the ≤2 LSB bound applies.
  - Latency is identical in both builds.

Test Plan:
- Reset then x_in=0x0100 (1.0) with a start pulse -> done exactly 18 cycles later; ln_out=0x0000 ±1; err=0; busy high throughout.
- x_in=0x0200 (2.0) -> ln_out=0x058B..0x058D. x_in=0x02B8 (2.71875) -> ln_out=0x07FE..0x0802.
- Extremes: x_in=0x0001 -> ln_out=0xD3A2..0xD3A6; x_in=0xFFFF -> ln_out=0x2C5A..0x2C5E. No saturation in either case.
- x_in=0x0000 -> done 2 cycles after start; ln_out=0x8000; err=1. A following valid start clears err with its result.
- Handshake:
  - Start during busy with a different x_in -> ignored; first result unchanged.
  - Start in the done cycle -> second result 18 cycles later.
  - reset asserted mid-ITER -> outputs 0 immediately, no done pulse.
- Sweep of 1000 random nonzero x_in against a real-valued ln model -> all within 2 LSB (1 LSB with CORDIC_LN_ROUND_EN).
